// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding,
// reset PC default and PC arithmetic constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10,
        ST_HALT  = 2'b11
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    // Mask of PC bits that lie above the instruction-memory byte range.
    function automatic logic [31:0] hi_mask(input int unsigned aw);
        return ~((32'd1 << (aw + 2)) - 32'd1);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch control/status bundle between the pipeline
// controller (master) and the PC fetch unit (slave).
interface pc_fetch_unit_if #(
    parameter int unsigned IM_AWIDTH = 8
);
    logic                 run;
    logic                 stall;
    logic                 br_taken;
    logic [15:0]          br_imm;
    logic                 jmp;
    logic [25:0]          jmp_idx;
    logic                 jr;
    logic [31:0]          jr_addr;
    logic                 halt_req;
    logic [31:0]          pc;
    logic [IM_AWIDTH-1:0] im_addr;
    logic [31:0]          pc_plus4;
    logic                 fetch_valid;
    logic                 err;
    logic [31:0]          icount;

    modport master (
        output run, stall, br_taken, br_imm,
        output jmp, jmp_idx, jr, jr_addr, halt_req,
        input  pc, im_addr, pc_plus4,
        input  fetch_valid, err, icount
    );

    modport slave (
        input  run, stall, br_taken, br_imm,
        input  jmp, jmp_idx, jr, jr_addr, halt_req,
        output pc, im_addr, pc_plus4,
        output fetch_valid, err, icount
    );
endinterface

// File: rtl/npc_sel.sv
// Next-PC selection: jr > jmp > branch > sequential,
// plus misaligned / out-of-range target detection.
module npc_sel
    import cpu_pkg::*;
#(
    parameter int unsigned IM_AWIDTH = 8
) (
    input  logic [31:0] pc_plus4,
    input  logic        br_taken,
    input  logic [15:0] br_imm,
    input  logic        jmp,
    input  logic [25:0] jmp_idx,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] npc,
    output logic        fault
);
    localparam logic [31:0] HI = hi_mask(IM_AWIDTH);

    logic [31:0] br_off;

    assign br_off = {{14{br_imm[15]}}, br_imm, 2'b00};

    // Priority-ordered redirect mux.
    always_comb begin
        npc = pc_plus4;
        priority case (1'b1)
            jr:       npc = jr_addr;
            jmp:      npc = {pc_plus4[31:28], jmp_idx, 2'b00};
            br_taken: npc = pc_plus4 + br_off;
            default:  npc = pc_plus4;
        endcase
    end

    assign fault = (npc[1:0] != 2'b00) || ((npc & HI) != 32'd0);
endmodule

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: fetch FSM, PC register, sticky fault
// flag and retired-fetch counter.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned IM_AWIDTH = 8,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_fetch_unit_if.slave  bus
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  icount_q, icount_d;
    logic         err_q, err_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  npc;
    logic         npc_fault;
    logic         active;
    logic         go;
    logic         adv;
    logic         fault_hit;
    logic         fetch_valid;

    assign pc_plus4  = pc_q + PC_STEP;
    assign active    = (state_q == ST_RUN) || (state_q == ST_STALL);
    assign go        = active && !bus.halt_req && !bus.stall;
    assign adv       = go && !npc_fault;
    assign fault_hit = go && npc_fault;

    npc_sel #(
        .IM_AWIDTH (IM_AWIDTH)
    ) u_npc_sel (
        .pc_plus4 (pc_plus4),
        .br_taken (bus.br_taken),
        .br_imm   (bus.br_imm),
        .jmp      (bus.jmp),
        .jmp_idx  (bus.jmp_idx),
        .jr       (bus.jr),
        .jr_addr  (bus.jr_addr),
        .npc      (npc),
        .fault    (npc_fault)
    );

    // State, PC, fault and counter registers; reset is immediate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            err_q    <= 1'b0;
            icount_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            err_q    <= err_d;
            icount_q <= icount_d;
        end
    end

    // Next-state logic: halt and faults outrank stall.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.run) state_d = ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                if (bus.halt_req || fault_hit) state_d = ST_HALT;
                else if (bus.stall)            state_d = ST_STALL;
                else                           state_d = ST_RUN;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath updates: PC and count move only on a clean advance.
    always_comb begin
        pc_d     = pc_q;
        icount_d = icount_q;
        err_d    = err_q | fault_hit;
        if (adv) begin
            pc_d     = npc;
            icount_d = icount_q + 32'd1;
        end
    end

    // Output decode from the current state.
    always_comb begin
        fetch_valid = 1'b0;
        unique case (state_q)
            ST_RUN, ST_STALL: fetch_valid = 1'b1;
            default:          fetch_valid = 1'b0;
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.im_addr     = pc_q[IM_AWIDTH+1:2];
    assign bus.pc_plus4    = pc_plus4;
    assign bus.fetch_valid = fetch_valid;
    assign bus.err         = err_q;
    assign bus.icount      = icount_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch,
// redirects, stall, halt, faults and async reset.
module tb_pc_fetch_unit;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    pc_fetch_unit_if #(.IM_AWIDTH(8)) bus ();

    pc_fetch_unit #(
        .IM_AWIDTH (8),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.run      = 1'b0;
        bus.stall    = 1'b0;
        bus.br_taken = 1'b0;
        bus.br_imm   = 16'h0;
        bus.jmp      = 1'b0;
        bus.jmp_idx  = 26'h0;
        bus.jr       = 1'b0;
        bus.jr_addr  = 32'h0;
        bus.halt_req = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clr();
        rst_n = 1'b0;
        #3;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_err", {31'b0, bus.err}, 32'h0);
        chk("rst_icount", bus.icount, 32'h0);
        chk("rst_fv", {31'b0, bus.fetch_valid}, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_fv", {31'b0, bus.fetch_valid}, 32'h0);
        chk("idle_pc", bus.pc, 32'h0);

        // sequential fetch
        bus.run = 1'b1;
        step();
        chk("run_fv", {31'b0, bus.fetch_valid}, 32'h1);
        chk("seq_pc0", bus.pc, 32'h00);
        chk("seq_im0", {24'b0, bus.im_addr}, 32'd0);
        step();
        chk("seq_pc1", bus.pc, 32'h04);
        chk("seq_im1", {24'b0, bus.im_addr}, 32'd1);
        step();
        chk("seq_pc2", bus.pc, 32'h08);
        chk("seq_im2", {24'b0, bus.im_addr}, 32'd2);
        step();
        chk("seq_pc3", bus.pc, 32'h0C);
        chk("seq_im3", {24'b0, bus.im_addr}, 32'd3);
        step();
        chk("seq_pc4", bus.pc, 32'h10);
        chk("seq_im4", {24'b0, bus.im_addr}, 32'd4);
        chk("seq_icount", bus.icount, 32'd4);

        // stall holds pc and masks the jump
        bus.stall   = 1'b1;
        bus.jmp     = 1'b1;
        bus.jmp_idx = 26'h38;
        step();
        chk("stall_pc1", bus.pc, 32'h10);
        step();
        chk("stall_pc2", bus.pc, 32'h10);
        step();
        chk("stall_pc3", bus.pc, 32'h10);
        chk("stall_icount", bus.icount, 32'd4);
        chk("stall_fv", {31'b0, bus.fetch_valid}, 32'h1);
        bus.stall = 1'b0;
        step();
        chk("unstall_jmp_pc", bus.pc, 32'hE0);
        chk("unstall_icount", bus.icount, 32'd5);
        bus.jmp = 1'b0;

        // taken branch backwards
        bus.jr      = 1'b1;
        bus.jr_addr = 32'h20;
        step();
        chk("jr_pc20", bus.pc, 32'h20);
        bus.jr       = 1'b0;
        bus.br_taken = 1'b1;
        bus.br_imm   = 16'hFFFE;
        step();
        chk("br_pc", bus.pc, 32'h1C);
        chk("br_im", {24'b0, bus.im_addr}, 32'd7);
        chk("br_icount", bus.icount, 32'd7);
        bus.br_taken = 1'b0;

        // absolute jump with link value
        bus.jr      = 1'b1;
        bus.jr_addr = 32'h48;
        step();
        bus.jr      = 1'b0;
        bus.jmp     = 1'b1;
        bus.jmp_idx = 26'h38;
        #1;
        chk("jmp_pc_plus4", bus.pc_plus4, 32'h4C);
        step();
        chk("jmp_pc", bus.pc, 32'hE0);
        chk("jmp_im", {24'b0, bus.im_addr}, 32'd56);

        // jr outranks jmp and branch
        bus.jr       = 1'b1;
        bus.jr_addr  = 32'hE4;
        bus.jmp_idx  = 26'h01;
        bus.br_taken = 1'b1;
        bus.br_imm   = 16'h0004;
        step();
        chk("prio_pc", bus.pc, 32'hE4);
        chk("prio_icount", bus.icount, 32'd10);
        bus.jmp      = 1'b0;
        bus.br_taken = 1'b0;

        // misaligned jr target faults
        bus.jr_addr = 32'hE9;
        step();
        chk("mis_err", {31'b0, bus.err}, 32'h1);
        chk("mis_pc", bus.pc, 32'hE4);
        chk("mis_fv", {31'b0, bus.fetch_valid}, 32'h0);
        chk("mis_icount", bus.icount, 32'd10);
        bus.jr = 1'b0;
        step();
        chk("halt_sticky_pc", bus.pc, 32'hE4);
        chk("halt_sticky_fv", {31'b0, bus.fetch_valid}, 32'h0);

        // async reset without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", bus.pc, 32'h0);
        chk("arst_err", {31'b0, bus.err}, 32'h0);
        chk("arst_icount", bus.icount, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        bus.jr      = 1'b1;
        bus.jr_addr = 32'h3FC;
        step();
        chk("last_pc", bus.pc, 32'h3FC);
        bus.jr = 1'b0;
        step();
        chk("oor_err", {31'b0, bus.err}, 32'h1);
        chk("oor_pc", bus.pc, 32'h3FC);
        chk("oor_fv", {31'b0, bus.fetch_valid}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("oor_rst_pc", bus.pc, 32'h0);
        chk("oor_rst_err", {31'b0, bus.err}, 32'h0);
        chk("oor_rst_fv", {31'b0, bus.fetch_valid}, 32'h0);

        // halt request beats stall and redirects
        step();
        rst_n = 1'b1;
        step();
        chk("re_run_pc", bus.pc, 32'h0);
        bus.halt_req = 1'b1;
        bus.stall    = 1'b1;
        bus.jmp      = 1'b1;
        bus.jmp_idx  = 26'h10;
        step();
        chk("halt_pc", bus.pc, 32'h0);
        chk("halt_fv", {31'b0, bus.fetch_valid}, 32'h0);
        chk("halt_err", {31'b0, bus.err}, 32'h0);
        bus.halt_req = 1'b0;
        bus.stall    = 1'b0;
        step();
        chk("halt_stays_pc", bus.pc, 32'h0);
        chk("halt_stays_icount", bus.icount, 32'h0);
        clr();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
